mem_access_unit: RTL

Memory-stage access controller of the image-filter processor pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register, turning each instruction's memory control bits into accesses on the 32-bit word data memory (fixed one-cycle synchronous read) and the 8-bit image memory (variable-latency req/ack). It returns the loaded word (`Do`) and byte (`Dob`) consumed by MEM/WB, and stalls the pipeline while an access is outstanding.

---
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage access controller: single-cycle word stores, two-cycle word loads, req/ack image
// accesses. Define MEM_ACCESS_TIMEOUT_EN to add the image-ack watchdog (err output).
module mem_access_unit #(
  parameter int unsigned DM_AW       = 10,
  parameter int unsigned IM_AW       = 17,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             MEM_RD_In,
  input  logic             MEM_WR_In,
  input  logic             BYTE_In,
  input  logic [31:0]      Addr_In,
  input  logic [31:0]      Store_In,
  input  logic [7:0]       StoreB_In,
  output logic [DM_AW-1:0] dm_addr,
  output logic             dm_en,
  output logic             dm_we,
  output logic [31:0]      dm_din,
  input  logic [31:0]      dm_dout,
  output logic             im_req,
  output logic             im_we,
  output logic [IM_AW-1:0] im_addr,
  output logic [7:0]       im_din,
  input  logic             im_ack,
  input  logic [7:0]       im_dout,
  output logic [31:0]      Do,
  output logic [7:0]       Dob,
  output logic             stall,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StWrd, StBwait, StDone} state_e;

  state_e             state_q, state_d;
  logic [31:0]        do_q, do_d;
  logic [7:0]         dob_q, dob_d;
  logic               im_req_q, im_req_d;
  logic               im_we_q, im_we_d;
  logic [IM_AW-1:0]   im_addr_q, im_addr_d;
  logic [7:0]         im_din_q, im_din_d;
  logic               done_q, done_d;
  logic               access;
  logic               unused_addr;

  assign access      = req_valid & (MEM_RD_In | MEM_WR_In);
  // Only a slice of the address reaches either memory.
  assign unused_addr = ^Addr_In;

  assign dm_addr = Addr_In[DM_AW+1:2];
  assign dm_din  = Store_In;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // Counts BWAIT cycles; zero on every entry since it is cleared outside BWAIT.
  assign cnt_d = (state_q == StBwait) ? cnt_q + 1'b1 : '0;
  assign err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign err            = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    do_d      = do_q;
    dob_d     = dob_q;
    im_req_d  = im_req_q;
    im_we_d   = im_we_q;
    im_addr_d = im_addr_q;
    im_din_d  = im_din_q;
    done_d    = 1'b0;
    stall     = 1'b0;
    dm_en     = 1'b0;
    dm_we     = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    err_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (BYTE_In) begin
            stall     = 1'b1;
            im_req_d  = 1'b1;
            im_we_d   = MEM_WR_In;
            im_addr_d = Addr_In[IM_AW-1:0];
            im_din_d  = StoreB_In;
            state_d   = StBwait;
          end else begin
            dm_en = 1'b1;
            if (MEM_WR_In) begin
              dm_we = 1'b1;
            end else begin
              stall   = 1'b1;
              state_d = StWrd;
            end
          end
        end
      end
      StWrd: begin
        stall   = 1'b1;
        do_d    = dm_dout;
        done_d  = 1'b1;
        state_d = StDone;
      end
      StBwait: begin
        stall = 1'b1;
        if (im_ack) begin
          if (!im_we_q) dob_d = im_dout;
          im_req_d = 1'b0;
          done_d   = 1'b1;
          state_d  = StDone;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          if (!im_we_q) dob_d = 8'h00;
          im_req_d = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          state_d  = StDone;
        end
`endif
      end
      // Inputs still show the finished instruction here; do not restart it.
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      do_q      <= '0;
      dob_q     <= '0;
      im_req_q  <= 1'b0;
      im_we_q   <= 1'b0;
      im_addr_q <= '0;
      im_din_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      do_q      <= do_d;
      dob_q     <= dob_d;
      im_req_q  <= im_req_d;
      im_we_q   <= im_we_d;
      im_addr_q <= im_addr_d;
      im_din_q  <= im_din_d;
      done_q    <= done_d;
    end
  end

  assign Do      = do_q;
  assign Dob     = dob_q;
  assign im_req  = im_req_q;
  assign im_we   = im_we_q;
  assign im_addr = im_addr_q;
  assign im_din  = im_din_q;
  assign done    = done_q;

endmodule
